// File: rtl/ped_sched_pkg.sv
// ---------------------------------------------------------------------------
// ped_sched_pkg
// Shared types and helpers for the pedestrian crossing scheduler.
//   sched_state_t : scheduler FSM state encoding
//   RR_MAX        : widest request vector rr_select can scan
//   rr_select     : round-robin pick of the first set bit at or above a
//                   pointer, wrapping at n; returns -1 when nothing is set
// ---------------------------------------------------------------------------
package ped_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PENDING = 2'd1,
      S_GRANT   = 2'd2
   } sched_state_t;

   localparam int RR_MAX = 32;

   function automatic int rr_select(input logic [RR_MAX-1:0] req,
                                    input int                ptr,
                                    input int                n);
      int idx;
      int found;
      found = -1;
      for (int k = 0; k < RR_MAX; k++) begin
         if (k < n && found < 0) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (req[idx]) found = idx;
         end
      end
      return found;
   endfunction

endpackage

// File: rtl/btn_sync_debounce.sv
// ---------------------------------------------------------------------------
// btn_sync_debounce
// One push-button channel: inversion, 2-flop synchroniser, debounce counter
// and a single-cycle press pulse on the debounced rising edge.
//   clk     : system clock
//   nreset  : synchronous active-low reset
//   btn_n   : raw active-low button, asynchronous to clk
//   press   : one-cycle pulse when the debounced level goes to pressed
// ---------------------------------------------------------------------------
module btn_sync_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic nreset,
   input  logic btn_n,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync_p0;
   logic          sync_p1;
   logic          level;
   logic [CW-1:0] cnt;
   logic          settle;

   // The counter has seen DEBOUNCE_CYCLES-1 differing cycles already; this
   // cycle is the last one needed to accept the new level.
   assign settle = (sync_p1 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

   // Synchroniser stage: pressed is carried as 1 from here on.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= ~btn_n;
         sync_p1 <= sync_p0;
      end
   end

   // Debounce stage: any cycle where the synchronised level matches the
   // accepted level restarts the count.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= settle && sync_p1;
         if (sync_p1 == level) begin
            cnt <= '0;
         end else if (settle) begin
            level <= sync_p1;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ped_crossing_scheduler.sv
// ---------------------------------------------------------------------------
// ped_crossing_scheduler
// Shares the single pedestrian phase among N_CROSS crosswalk buttons. Each
// debounced press latches a request; while any request is pending solicitud
// asks the light FSM for a window, and each slot_start/slot_end window grants
// exactly one crosswalk chosen round-robin.
//
// Optional feature macro: PED_SCHED_AGING_EN
//   defined   : requests waiting T_MAXWAIT seconds are served first
//   undefined : pure round-robin, no tick or wait counters
//
// Ports
//   clk        : system clock
//   nreset     : synchronous active-low reset
//   b_npeaton  : raw active-low push-buttons (N_CROSS), asynchronous
//   slot_start : one-cycle pulse, pedestrian green begins
//   slot_end   : one-cycle pulse, pedestrian green ends
//   solicitud  : high while any request is pending
//   pending    : latched requests (N_CROSS)
//   grant      : one-hot walk enable for the served crosswalk, else 0
//   grant_id   : index of the served crosswalk, 0 when no grant
// ---------------------------------------------------------------------------
module ped_crossing_scheduler
   import ped_sched_pkg::*;
#(
   parameter int N_CROSS         = 4,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int FPGAFREQ        = 50_000_000,
   parameter int T_MAXWAIT       = 60
) (
   input  logic                       clk,
   input  logic                       nreset,
   input  logic [N_CROSS-1:0]         b_npeaton,
   input  logic                       slot_start,
   input  logic                       slot_end,
   output logic                       solicitud,
   output logic [N_CROSS-1:0]         pending,
   output logic [N_CROSS-1:0]         grant,
   output logic [$clog2(N_CROSS)-1:0] grant_id
);

   localparam int IDW = $clog2(N_CROSS);

   if (N_CROSS < 2 || N_CROSS > RR_MAX || DEBOUNCE_CYCLES < 1 ||
       FPGAFREQ < 1 || T_MAXWAIT < 1) begin : g_bad_cfg
      $error("ped_crossing_scheduler: illegal parameter set");
   end

   sched_state_t       state;
   sched_state_t       state_nxt;
   logic [N_CROSS-1:0] press_v;
   logic [N_CROSS-1:0] pending_nxt;
   logic [N_CROSS-1:0] grant_nxt;
   logic [IDW-1:0]     grant_id_nxt;
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     rr_ptr_nxt;
   int                 win_i;
   logic               win_ok;
   logic [IDW-1:0]     win_idx;

   // Button front end, one channel per crosswalk.
   for (genvar i = 0; i < N_CROSS; i++) begin : g_btn
      btn_sync_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk   (clk),
         .nreset(nreset),
         .btn_n (b_npeaton[i]),
         .press (press_v[i])
      );
   end

`ifdef PED_SCHED_AGING_EN
   localparam int TW = (FPGAFREQ < 2) ? 1 : $clog2(FPGAFREQ);
   localparam int AW = $clog2(T_MAXWAIT + 1);

   logic [TW-1:0]      tick_cnt;
   logic               tick;
   logic [AW-1:0]      wait_cnt [N_CROSS];
   logic [N_CROSS-1:0] aged;

   assign tick = (tick_cnt == TW'(FPGAFREQ - 1));

   always_ff @(posedge clk) begin
      if (!nreset || tick) tick_cnt <= '0;
      else                 tick_cnt <= tick_cnt + 1'b1;
   end

   for (genvar i = 0; i < N_CROSS; i++) begin : g_age
      always_ff @(posedge clk) begin
         if (!nreset || !pending[i])
            wait_cnt[i] <= '0;
         else if (tick && wait_cnt[i] != AW'(T_MAXWAIT))
            wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
      assign aged[i] = (wait_cnt[i] == AW'(T_MAXWAIT));
   end
`endif

   // Winner selection works on the registered pending vector, so a press
   // that debounces in the slot_start cycle cannot take part.
   always_comb begin
`ifdef PED_SCHED_AGING_EN
      win_i = rr_select(RR_MAX'(aged), int'(rr_ptr), N_CROSS);
      if (win_i < 0)
         win_i = rr_select(RR_MAX'(pending), int'(rr_ptr), N_CROSS);
`else
      win_i = rr_select(RR_MAX'(pending), int'(rr_ptr), N_CROSS);
`endif
      win_ok  = (win_i >= 0);
      win_idx = win_ok ? IDW'(win_i) : '0;
   end

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      grant_id_nxt = grant_id;
      rr_ptr_nxt   = rr_ptr;
      // The crosswalk currently walking cannot queue itself again.
      pending_nxt  = pending | (press_v & ((state == S_GRANT) ? ~grant : '1));

      case (state)
         S_IDLE: begin
            if (pending != '0) state_nxt = S_PENDING;
         end
         S_PENDING: begin
            if (slot_start && win_ok) begin
               grant_nxt            = '0;
               grant_nxt[win_idx]   = 1'b1;
               grant_id_nxt         = win_idx;
               pending_nxt[win_idx] = 1'b0;
               state_nxt            = S_GRANT;
            end else if (pending == '0) begin
               state_nxt = S_IDLE;
            end
         end
         S_GRANT: begin
            if (slot_end) begin
               grant_nxt    = '0;
               grant_id_nxt = '0;
               rr_ptr_nxt   = (grant_id == IDW'(N_CROSS - 1)) ? '0 : grant_id + 1'b1;
               state_nxt    = (pending_nxt != '0) ? S_PENDING : S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state    <= S_IDLE;
         pending  <= '0;
         grant    <= '0;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else begin
         state    <= state_nxt;
         pending  <= pending_nxt;
         grant    <= grant_nxt;
         grant_id <= grant_id_nxt;
         rr_ptr   <= rr_ptr_nxt;
      end
   end

   assign solicitud = |pending;

endmodule
